contactor_drive_d: RTL and testbench

Drive and supervision stage for contactor D in the ring interlock circuit, directly downstream of the contactor D interlock. Takes the operator close request plus the interlock permit, drives the contactor coil through a supervised close/open sequence, and debounces the auxiliary-contact feedback. Publishes the clean feedback back to the interlock feedback network. Latches fail-to-close, fail-to-open and feedback-mismatch faults until explicitly cleared.

---
 rtl/contactor_drive_d.sv | 158 +++++++++++++++
 tb/tb_contactor_drive_d.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/contactor_drive_d.sv
// Contactor D coil drive: supervised close/open sequencing against debounced auxiliary feedback,
// with latched fail-to-close, fail-to-open and feedback-mismatch faults.
module contactor_drive_d #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CLOSE_TIMEOUT   = 1000,
    parameter int OPEN_TIMEOUT    = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_close_req,
    input  logic       i_permit,
    input  logic       i_fb_raw,
    input  logic       i_fault_clr,
    output logic       o_coil,
    output logic       o_fb_closed,
    output logic [2:0] o_state,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    typedef enum logic [2:0] {
        S_OPEN    = 3'd0,
        S_CLOSING = 3'd1,
        S_CLOSED  = 3'd2,
        S_OPENING = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_CLOSE    = 2'b01;
    localparam logic [1:0] FC_OPEN     = 2'b10;
    localparam logic [1:0] FC_MISMATCH = 2'b11;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [1:0]       fault_code;
    logic             fb_meta_p0;
    logic             fb_sync_p1;
    logic [CNT_W-1:0] deb_cnt;
    logic             fb_deb;
    logic             run_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0/p1: two-flop synchroniser for the asynchronous auxiliary contact
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fb_meta_p0 <= 1'b0;
            fb_sync_p1 <= 1'b0;
        end else begin
            fb_meta_p0 <= i_fb_raw;
            fb_sync_p1 <= fb_meta_p0;
        end
    end

    // Debounce: fb_deb follows fb_sync_p1 only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            deb_cnt <= '0;
            fb_deb  <= 1'b0;
        end else if (fb_sync_p1 == fb_deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            fb_deb  <= fb_sync_p1;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    assign run_ok = i_close_req & i_permit;

    // Sequencer: the timer is zeroed on every transition so it always measures dwell in the current state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_OPEN;
            timer      <= '0;
            fault_code <= FC_NONE;
        end else begin
            case (state)
                S_OPEN: begin
                    if (fb_deb) begin
                        state      <= S_FAULT;
                        timer      <= '0;
                        fault_code <= FC_MISMATCH;
                    end else if (run_ok) begin
                        state <= S_CLOSING;
                        timer <= '0;
                    end
                end
                S_CLOSING: begin
                    if (!run_ok) begin
                        state <= S_OPENING;
                        timer <= '0;
                    end else if (fb_deb) begin
                        state <= S_CLOSED;
                        timer <= '0;
                    end else if (timer == CLOSE_LAST) begin
                        state      <= S_FAULT;
                        timer      <= '0;
                        fault_code <= FC_CLOSE;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                S_CLOSED: begin
                    if (!run_ok) begin
                        state <= S_OPENING;
                        timer <= '0;
                    end else if (!fb_deb) begin
                        state      <= S_FAULT;
                        timer      <= '0;
                        fault_code <= FC_MISMATCH;
                    end
                end
                S_OPENING: begin
                    // Request and permit are deliberately ignored until the contact is proven open
                    if (!fb_deb) begin
                        state <= S_OPEN;
                        timer <= '0;
                    end else if (timer == OPEN_LAST) begin
                        state      <= S_FAULT;
                        timer      <= '0;
                        fault_code <= FC_OPEN;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                S_FAULT: begin
                    if (i_fault_clr && !fb_deb && !i_close_req) begin
                        state      <= S_OPEN;
                        timer      <= '0;
                        fault_code <= FC_NONE;
                    end
                end
                default: begin
                    state <= S_OPEN;
                    timer <= '0;
                end
            endcase
        end
    end

    assign o_coil       = (state == S_CLOSING) || (state == S_CLOSED);
    assign o_fault      = (state == S_FAULT);
    assign o_state      = state;
    assign o_fault_code = fault_code;
    assign o_fb_closed  = fb_deb;

endmodule

// File: tb/tb_contactor_drive_d.sv
// Scoreboard bench for contactor_drive_d: a timestamp/history reference model predicts every
// post-edge output; a negedge monitor pops and compares.
module tb_contactor_drive_d;

    localparam int D  = 4;
    localparam int CT = 20;
    localparam int OT = 20;
    localparam int CW = 16;

    localparam int ST_OPEN    = 0;
    localparam int ST_CLOSING = 1;
    localparam int ST_CLOSED  = 2;
    localparam int ST_OPENING = 3;
    localparam int ST_FAULT   = 4;

    logic       clk = 1'b0;
    logic       rst, req, permit, raw, clr;
    logic       coil, fbc, fault;
    logic [2:0] st;
    logic [1:0] code;

    always #5 clk = ~clk;

    contactor_drive_d #(
        .DEBOUNCE_CYCLES(D),
        .CLOSE_TIMEOUT  (CT),
        .OPEN_TIMEOUT   (OT),
        .CNT_W          (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_close_req (req),
        .i_permit    (permit),
        .i_fb_raw    (raw),
        .i_fault_clr (clr),
        .o_coil      (coil),
        .o_fb_closed (fbc),
        .o_state     (st),
        .o_fault     (fault),
        .o_fault_code(code)
    );

    typedef struct packed {
        logic       coil;
        logic       fb;
        logic [2:0] st;
        logic       fault;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: state plus the edge number it was entered at, raw-sample history, debounce window
    int       m_state;
    bit       m_deb;
    bit [1:0] m_code;
    int       m_entered;
    int       edge_no = 0;
    bit       raw_hist[$];
    bit       deb_win[$];

    task automatic go(input int s);
        m_state   = s;
        m_entered = edge_no;
    endtask

    task automatic model_edge();
        bit sync_now, deb_old, all_diff;
        int dwell;
        edge_no++;
        if (rst) begin
            raw_hist.delete();
            raw_hist.push_back(1'b0);
            raw_hist.push_back(1'b0);
            deb_win.delete();
            m_deb  = 1'b0;
            m_code = 2'b00;
            go(ST_OPEN);
            return;
        end
        // raw sampled two edges ago is what the debouncer sees this edge
        sync_now = raw_hist[raw_hist.size() - 2];
        raw_hist.push_back(raw);
        if (raw_hist.size() > 4) void'(raw_hist.pop_front());
        deb_old = m_deb;
        deb_win.push_back(sync_now);
        if (deb_win.size() > D) void'(deb_win.pop_front());
        all_diff = (deb_win.size() == D);
        foreach (deb_win[i]) if (deb_win[i] == deb_old) all_diff = 1'b0;
        if (all_diff) begin
            m_deb = !deb_old;
            deb_win.delete();
        end
        dwell = edge_no - m_entered;
        case (m_state)
            ST_OPEN: begin
                if (deb_old) begin go(ST_FAULT); m_code = 2'b11; end
                else if (req && permit) go(ST_CLOSING);
            end
            ST_CLOSING: begin
                if (!(req && permit)) go(ST_OPENING);
                else if (deb_old) go(ST_CLOSED);
                else if (dwell == CT) begin go(ST_FAULT); m_code = 2'b01; end
            end
            ST_CLOSED: begin
                if (!(req && permit)) go(ST_OPENING);
                else if (!deb_old) begin go(ST_FAULT); m_code = 2'b11; end
            end
            ST_OPENING: begin
                if (!deb_old) go(ST_OPEN);
                else if (dwell == OT) begin go(ST_FAULT); m_code = 2'b10; end
            end
            default: begin
                if (clr && !deb_old && !req) begin go(ST_OPEN); m_code = 2'b00; end
            end
        endcase
    endtask

    function automatic exp_t exp_now();
        exp_t e;
        e.coil  = (m_state == ST_CLOSING) || (m_state == ST_CLOSED);
        e.fb    = m_deb;
        e.st    = 3'(m_state);
        e.fault = (m_state == ST_FAULT);
        e.code  = m_code;
        return e;
    endfunction

    function automatic bit m_coil();
        return (m_state == ST_CLOSING) || (m_state == ST_CLOSED);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        exp_q.push_back(exp_now());
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("coil",       {2'b00, coil},  {2'b00, mon_e.coil});
            chk("fb_closed",  {2'b00, fbc},   {2'b00, mon_e.fb});
            chk("state",      st,             mon_e.st);
            chk("fault",      {2'b00, fault}, {2'b00, mon_e.fault});
            chk("fault_code", {1'b0, code},   {1'b0, mon_e.code});
        end
    end

    initial begin
        int len, mode, dly, pcnt;
        bit p_req, p_perm;
        rst = 1'b1; req = 1'b0; permit = 1'b0; raw = 1'b0; clr = 1'b0;
        steps(3);
        rst = 1'b0;
        steps(2);

        // Normal close, then permit drop and clean open
        req = 1'b1; permit = 1'b1;
        steps(6);
        raw = 1'b1;
        steps(10);
        permit = 1'b0;
        steps(2);
        raw = 1'b0;
        steps(8);
        req = 1'b0; permit = 1'b1;
        steps(2);

        // Fail-to-close, then acknowledge
        req = 1'b1;
        steps(24);
        req = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        steps(2);

        // Bounce rejection in OPEN, then a stuck-closed contact
        for (int i = 0; i < 30; i++) begin
            raw = ((i / 2) % 2) == 1;
            step();
        end
        raw = 1'b1;
        steps(10);
        raw = 1'b0;
        steps(8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        steps(2);

        // Welded contact during OPENING; acknowledge ignored until feedback debounces low
        req = 1'b1;
        steps(3);
        raw = 1'b1;
        steps(8);
        req = 1'b0;
        steps(24);
        clr = 1'b1;
        steps(3);
        raw = 1'b0;
        steps(8);
        clr = 1'b0;
        steps(2);

        // Reset while CLOSING with the timer at 7
        req = 1'b1;
        steps(8);
        rst = 1'b1;
        step();
        rst = 1'b0; req = 1'b0;
        steps(3);

        // Randomised phases with a plant that is healthy, stuck open, welded or bouncing
        pcnt = 0;
        for (int p = 0; p < 60; p++) begin
            len    = $urandom_range(20, 80);
            mode   = $urandom_range(0, 3);
            dly    = $urandom_range(1, 8);
            p_req  = ($urandom_range(0, 3) != 0);
            p_perm = ($urandom_range(0, 4) != 0);
            for (int c = 0; c < len; c++) begin
                req    = p_req;
                permit = p_perm ^ ($urandom_range(0, 49) == 0);
                clr    = ($urandom_range(0, 7) == 0);
                rst    = ($urandom_range(0, 399) == 0);
                case (mode)
                    0: begin
                        if (raw != m_coil()) begin
                            pcnt++;
                            if (pcnt >= dly) begin raw = m_coil(); pcnt = 0; end
                        end else pcnt = 0;
                    end
                    1: raw = 1'b0;
                    2: raw = 1'b1;
                    default: raw = $urandom_range(0, 1) == 1;
                endcase
                step();
            end
        end
        rst = 1'b0; clr = 1'b0;
        steps(2);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
